inv_sub_bytes: RTL

INV_SUB_BYTES -- requirements
Module: inv_sub_bytes

---
 rtl/aes_pkg.sv | 58 +++++
 rtl/inv_sub_bytes_if.sv | 13 +
 rtl/inv_sbox.sv | 12 +
 rtl/inv_sub_bytes_core.sv | 72 +++++++
 rtl/inv_sub_bytes.sv | 34 +++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, state/FSM types and GF(2^8) helpers for the InvSubBytes block.
// The GF arithmetic here is used to build the inverse S-box without any lookup ROM.
package aes_pkg;

  localparam int AES_BLOCK_W  = 128;
  localparam int AES_BYTE_W   = 8;
  localparam int AES_NB_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } isb_state_e;

  typedef logic [AES_BYTE_W-1:0]                    aes_byte_t;
  typedef logic [AES_NB_BYTES-1:0][AES_BYTE_W-1:0]  aes_state_t;

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic aes_byte_t gf_mul(input aes_byte_t a, input aes_byte_t b);
    aes_byte_t p;
    aes_byte_t aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // x^254 == x^-1 for x != 0, and maps 0 to 0 as AES requires.
  function automatic aes_byte_t gf_inv(input aes_byte_t x);
    aes_byte_t sq;
    aes_byte_t acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  // Inverse of the S-box affine map: a_i = b_(i+2) ^ b_(i+5) ^ b_(i+7) ^ 0x05_i.
  function automatic aes_byte_t inv_affine(input aes_byte_t b);
    aes_byte_t a;
    a = {b[1] ^ b[4] ^ b[6],
         b[0] ^ b[3] ^ b[5],
         b[7] ^ b[2] ^ b[4],
         b[6] ^ b[1] ^ b[3],
         b[5] ^ b[0] ^ b[2],
         b[4] ^ b[7] ^ b[1],
         b[3] ^ b[6] ^ b[0],
         b[2] ^ b[5] ^ b[7]};
    return a ^ 8'h05;
  endfunction

endpackage

// File: rtl/inv_sub_bytes_if.sv
// Valid/ready stream carrying one 128-bit AES state per transfer.
// master drives valid/data, slave drives ready.
interface inv_sub_bytes_if;
  import aes_pkg::*;

  logic                   valid;
  logic                   ready;
  logic [AES_BLOCK_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box: inverse affine map followed by GF(2^8) inversion.
// No table; a single instance is shared across all 16 bytes by the core.
module inv_sbox
  import aes_pkg::*;
(
  input  aes_byte_t cipher_byte,
  output aes_byte_t plain_byte
);

  assign plain_byte = gf_inv(inv_affine(cipher_byte));

endmodule

// File: rtl/inv_sub_bytes_core.sv
// InvSubBytes engine: one byte per clock through a single inverse S-box, 16 cycles per state.
// Accepts only in IDLE, presents result only in DONE and holds it until the consumer takes it.
module inv_sub_bytes_core
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  inv_sub_bytes_if.slave   in_bus,
  inv_sub_bytes_if.master  out_bus
);

  isb_state_e state_q;
  isb_state_e state_d;
  logic [3:0] cnt_q;
  aes_state_t data_q;
  logic       load;
  logic       step;
  aes_byte_t  sbox_in;
  aes_byte_t  sbox_out;

  // The only path from data_i to data_o goes through data_q and this counter-indexed mux.
  assign sbox_in = data_q[cnt_q];

  inv_sbox u_inv_sbox (
    .cipher_byte (sbox_in),
    .plain_byte  (sbox_out)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_bus.valid) begin
          load    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (cnt_q == 4'd15) state_d = DONE;
      end
      DONE: begin
        if (out_bus.ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        data_q <= in_bus.data;
        cnt_q  <= 4'd0;
      end else if (step) begin
        data_q[cnt_q] <= sbox_out;
        cnt_q         <= cnt_q + 4'd1;
      end
    end
  end

  assign in_bus.ready  = (state_q == IDLE);
  assign out_bus.valid = (state_q == DONE);
  assign out_bus.data  = data_q;

endmodule

// File: rtl/inv_sub_bytes.sv
// AES InvSubBytes block: 16-cycle fixed latency, one state in flight, valid/ready on both sides.
// Flat ports are bundled into stream interfaces for the engine.
module inv_sub_bytes
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [AES_BLOCK_W-1:0] data_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [AES_BLOCK_W-1:0] data_o
);

  inv_sub_bytes_if in_bus ();
  inv_sub_bytes_if out_bus ();

  assign in_bus.valid  = valid_i;
  assign in_bus.data   = data_i;
  assign ready_o       = in_bus.ready;

  assign out_bus.ready = ready_i;
  assign valid_o       = out_bus.valid;
  assign data_o        = out_bus.data;

  inv_sub_bytes_core u_core (
    .clk     (clk),
    .rst     (rst),
    .in_bus  (in_bus.slave),
    .out_bus (out_bus.master)
  );

endmodule
